// File: rtl/if_fetch_ctl.sv
// Instruction-fetch front end: issues sequential word fetches under a credit limit, buffers
// responses with their PC in a small FIFO for decode, and redirects on a MEM-stage taken
// branch by flushing the buffer and discarding responses still in flight.
module if_fetch_ctl #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // redirect from the branch controller
  input  logic        taken_i,
  input  logic [31:0] target_i,
  output logic        flush_o,
  // instruction memory
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  // decode side
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        ready_i
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW:0] CreditMax = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // architectural state
  logic [31:0]     fetch_pc;
  logic [31:0]     rsp_pc;
  logic [CntW-1:0] out_cnt;
  logic [CntW-1:0] fifo_cnt;
  logic [CntW-1:0] discard_cnt;
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [31:0]     fifo_instr [FIFO_DEPTH];
  logic [31:0]     fifo_pc    [FIFO_DEPTH];

  // derived control
  logic [31:0]     redirect_pc;
  logic [CntW:0]   credit_used;
  logic            has_credit;
  logic            req_fire;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic            unused_target_lsb;

  // Low target bits are ignored: fetches are always word aligned.
  assign redirect_pc       = {target_i[31:2], 2'b00};
  assign unused_target_lsb = ^target_i[1:0];

  // Both in-flight requests and buffered entries consume a FIFO slot, so a granted request
  // always has room when its response comes back.
  assign credit_used = {1'b0, out_cnt} + {1'b0, fifo_cnt};
  assign has_credit  = credit_used < CreditMax;

  // Gated by reset so the memory sees no request while the block is held in reset.
  assign instr_req_o  = rst_ni && !taken_i && has_credit;
  assign instr_addr_o = fetch_pc;
  assign flush_o      = taken_i;

  assign req_fire = instr_req_o && instr_gnt_i;
  // A response in the redirect cycle belongs to the old path and is dropped too.
  assign rsp_drop = instr_rvalid_i && ((discard_cnt != '0) || taken_i);
  assign push     = instr_rvalid_i && !rsp_drop;
  assign pop      = instr_valid_o && ready_i && !taken_i;

  assign instr_valid_o = (fifo_cnt != '0);
  assign instr_o       = fifo_instr[rd_ptr];
  assign pc_o          = fifo_pc[rd_ptr];

  // Request-side PC: jumps to the target on redirect, otherwise advances per grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc <= BOOT_ADDR;
    end else if (taken_i) begin
      fetch_pc <= redirect_pc;
    end else if (req_fire) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Response-side PC: labels each kept response with the address it was fetched from.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_pc <= BOOT_ADDR;
    end else if (taken_i) begin
      rsp_pc <= redirect_pc;
    end else if (push) begin
      rsp_pc <= rsp_pc + 32'd4;
    end
  end

  // Outstanding-request count: +1 per grant, -1 per response, unchanged when both occur.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt <= '0;
    end else begin
      unique case ({req_fire, instr_rvalid_i})
        2'b10:   out_cnt <= out_cnt + CntOne;
        2'b01:   out_cnt <= out_cnt - CntOne;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Stale-response count: on redirect every request still in flight is wrong-path. No grant
  // can happen in a taken cycle, so recomputing from out_cnt never double counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      discard_cnt <= '0;
    end else if (taken_i) begin
      discard_cnt <= out_cnt - CntW'(instr_rvalid_i);
    end else if (instr_rvalid_i && (discard_cnt != '0)) begin
      discard_cnt <= discard_cnt - CntOne;
    end
  end

  // FIFO occupancy and pointers; a redirect empties the buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (taken_i) begin
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CntOne;
        2'b01:   fifo_cnt <= fifo_cnt - CntOne;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero while empty after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (push) begin
      fifo_instr[wr_ptr] <= instr_rdata_i;
      fifo_pc[wr_ptr]    <= rsp_pc;
    end
  end

  // Invariants of the credit scheme.
  a_discard_le_out: assert property (@(posedge clk_i) disable iff (!rst_ni)
    discard_cnt <= out_cnt);
  a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    credit_used <= CreditMax);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> (fifo_cnt < CntW'(FIFO_DEPTH)) || pop);

endmodule
